// File: rtl/uart_tx_fifo_drain.sv
`timescale 1ns/1ps
// UART transmitter that pops words from the read side of the CDC FIFO and
// serialises each one as start bit, DATA_WIDTH data bits (LSB first) and
// STOP_BITS stop bits. Exactly one FIFO request is outstanding at a time.
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH     = 8,
  parameter int CLOCKS_PER_BIT = 868,
  parameter int STOP_BITS      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_valid,
  output logic                  fifo_req,
  output logic                  uart_txd,
  output logic                  busy
);

  localparam int STOP_CYCLES = CLOCKS_PER_BIT * STOP_BITS;
  localparam int BAUD_W      = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;
  localparam int BIT_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_BIT_LAST  = BAUD_W'(CLOCKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_STOP_LAST = BAUD_W'(STOP_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST       = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic                    req_q, req_d;
  logic                    txd_q, txd_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;

  // Next-state logic: request/accept handshake, then bit sequencing on the baud counter
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    txd_d   = txd_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        // fifo_empty is only looked at here, so a stale flag later cannot double-pop
        if (!fifo_empty) begin
          req_d   = 1'b1;
          state_d = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (fifo_valid) begin
          shift_d = fifo_data;
          txd_d   = 1'b0;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == BAUD_BIT_LAST) begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_BIT_LAST) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_STOP_LAST) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // Control registers; reset abandons any word in flight and idles the line high
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      txd_q   <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      txd_q   <= txd_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end

  // Data shift register; contents are don't-care until loaded in WAIT_DATA
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign fifo_req = req_q;
  assign uart_txd = txd_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_tx_fifo_drain: a FIFO model feeds DUT0 (8N1,
// 4 clocks/bit), a frame monitor decodes the line against queued expectations.
// DUT1 uses two stop bits and is checked cycle by cycle from the stimulus.
module tb_uart_tx_fifo_drain;

  localparam int CPB    = 4;
  localparam int FRAME0 = (1 + 8 + 1) * CPB;
  localparam int FRAME1 = (1 + 8 + 2) * CPB;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // DUT0 FIFO model and scoreboard storage
  logic [7:0] fmem [0:31];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] model_data  = 8'h00;
  logic       model_valid = 1'b0;
  logic       spur_valid  = 1'b0;
  logic       empty_glitch = 1'b0;
  logic [7:0] exp_mem [0:31];
  int         exp_wr = 0;
  int         exp_rd = 0;

  logic [7:0] fifo_data0;
  logic       fifo_empty0, fifo_valid0, fifo_req0, txd0, busy0;

  assign fifo_empty0 = (wr_ptr == rd_ptr) ? ~empty_glitch : 1'b0;
  assign fifo_valid0 = model_valid | spur_valid;
  assign fifo_data0  = spur_valid ? 8'h3C : model_data;

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLOCKS_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .fifo_data(fifo_data0), .fifo_empty(fifo_empty0),
    .fifo_valid(fifo_valid0), .fifo_req(fifo_req0), .uart_txd(txd0), .busy(busy0)
  );

  always @(posedge clk) begin
    model_valid <= 1'b0;
    if (fifo_req0 && (rd_ptr != wr_ptr)) begin
      model_data  <= fmem[rd_ptr % 32];
      model_valid <= 1'b1;
      rd_ptr      <= rd_ptr + 1;
    end
  end

  // DUT1: two stop bits, fixed word 0x80
  int         ld1  = 0;
  int         pop1 = 0;
  logic       valid1 = 1'b0;
  logic       empty1, req1, txd1, busy1;
  logic [7:0] data1;
  assign empty1 = (ld1 == pop1);
  assign data1  = 8'h80;

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLOCKS_PER_BIT(CPB), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .fifo_data(data1), .fifo_empty(empty1),
    .fifo_valid(valid1), .fifo_req(req1), .uart_txd(txd1), .busy(busy1)
  );

  always @(posedge clk) begin
    valid1 <= 1'b0;
    if (req1 && (ld1 != pop1)) begin
      valid1 <= 1'b1;
      pop1   <= pop1 + 1;
    end
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic line_bit(input logic [7:0] b, input int bi);
    if (bi == 0) return 1'b0;
    else if (bi <= 8) return b[3'(bi - 1)];
    else return 1'b1;
  endfunction

  // Monitor: req pulse width, frame decode against the expectation queue, gaps
  int         mon_k = 0;
  int         mon_bi = 0;
  bit         mon_in = 1'b0;
  logic [7:0] mon_exp = 8'h00;
  logic [7:0] mon_dec = 8'h00;
  int         gap_cnt = 0;
  int         frames_done = 0;
  int         req_cnt = 0;
  bit         prev_req = 1'b0;
  bit         check_gap = 1'b0;
  int         gap_base = 0;

  always @(negedge clk) begin
    if (fifo_req0) begin
      req_cnt++;
      check_bit("req_one_cycle", prev_req, 1'b0);
    end
    prev_req = fifo_req0;
    if (reset) begin
      mon_in  = 1'b0;
      gap_cnt = 0;
    end else begin
      if (!mon_in) begin
        if (txd0 == 1'b0) begin
          if (check_gap && (frames_done > gap_base))
            check_int("interframe_gap", gap_cnt, 3);
          check_bit("frame_expected", (exp_rd != exp_wr), 1'b1);
          if (exp_rd != exp_wr) begin
            mon_exp = exp_mem[exp_rd % 32];
            exp_rd++;
          end else begin
            mon_exp = 8'h00;
          end
          mon_in  = 1'b1;
          mon_k   = 0;
          mon_dec = 8'h00;
        end else begin
          gap_cnt++;
        end
      end
      if (mon_in) begin
        mon_bi = mon_k / CPB;
        check_bit("line_bit", txd0, line_bit(mon_exp, mon_bi));
        check_bit("busy_in_frame", busy0, 1'b1);
        if ((mon_bi >= 1) && (mon_bi <= 8) && ((mon_k % CPB) == CPB / 2))
          mon_dec[3'(mon_bi - 1)] = txd0;
        if (mon_k == FRAME0 - 1) begin
          check_int("frame_decode", int'(mon_dec), int'(mon_exp));
          mon_in = 1'b0;
          frames_done++;
          gap_cnt = 0;
        end else begin
          mon_k++;
        end
      end
    end
  end

  task automatic push_word(input logic [7:0] b);
    fmem[wr_ptr % 32]    = b;
    exp_mem[exp_wr % 32] = b;
    wr_ptr++;
    exp_wr++;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_low(input int which);
    int n;
    n = 0;
    while (n < 50) begin
      cycle();
      n++;
      if (((which == 0) ? txd0 : txd1) == 1'b0) return;
    end
    check_bit("start_bit_timeout", 1'b1, 1'b0);
  endtask

  task automatic wait_frames(input int target, input int limit);
    int n;
    n = 0;
    while ((frames_done < target) && (n < limit)) begin
      cycle();
      n++;
    end
    check_int("frames_completed", frames_done, target);
  endtask

  int base_req;
  int base_fr;

  initial begin
    // Reset held for three cycles with both FIFOs empty
    reset = 1'b1;
    repeat (3) begin
      cycle();
      check_bit("reset_txd", txd0, 1'b1);
      check_bit("reset_req", fifo_req0, 1'b0);
      check_bit("reset_busy", busy0, 1'b0);
      check_bit("reset_txd1", txd1, 1'b1);
    end
    reset = 1'b0;
    base_req = req_cnt;
    repeat (100) cycle();
    check_int("idle_no_req", req_cnt - base_req, 0);
    check_bit("idle_busy", busy0, 1'b0);

    // Single byte 0xA5: 3-cycle latency, 40-cycle frame, busy drop
    base_req = req_cnt;
    base_fr  = frames_done;
    push_word(8'hA5);
    cycle();
    check_bit("lat_req_t1", fifo_req0, 1'b1);
    check_bit("lat_busy_t1", busy0, 1'b1);
    check_bit("lat_txd_t1", txd0, 1'b1);
    cycle();
    check_bit("lat_req_t2", fifo_req0, 1'b0);
    check_bit("lat_txd_t2", txd0, 1'b1);
    cycle();
    check_bit("lat_txd_t3", txd0, 1'b0);
    repeat (FRAME0 - 1) cycle();
    check_bit("last_stop_busy", busy0, 1'b1);
    check_bit("last_stop_txd", txd0, 1'b1);
    cycle();
    check_bit("busy_drop", busy0, 1'b0);
    repeat (5) cycle();
    check_int("single_req_count", req_cnt - base_req, 1);
    check_int("single_frames", frames_done - base_fr, 1);

    // Back-to-back 0x00, 0xFF, 0x55 preloaded
    base_req  = req_cnt;
    base_fr   = frames_done;
    gap_base  = frames_done;
    check_gap = 1'b1;
    push_word(8'h00);
    push_word(8'hFF);
    push_word(8'h55);
    wait_frames(base_fr + 3, 300);
    check_gap = 1'b0;
    repeat (5) cycle();
    check_int("b2b_req_count", req_cnt - base_req, 3);

    // Spurious valid pulses and empty toggling during a 0xC3 frame
    base_req = req_cnt;
    base_fr  = frames_done;
    push_word(8'hC3);
    wait_low(0);
    for (int k = 0; k < 36; k++) begin
      spur_valid   = ((k % 5) == 2);
      empty_glitch = ((k % 3) == 0);
      cycle();
    end
    spur_valid   = 1'b0;
    empty_glitch = 1'b0;
    wait_frames(base_fr + 1, 60);
    repeat (10) cycle();
    check_int("spur_req_count", req_cnt - base_req, 1);

    // Reset during data bit 3 of 0x96, then 0x3C must go out cleanly
    base_fr = frames_done;
    push_word(8'h96);
    wait_low(0);
    repeat (17) cycle();
    reset = 1'b1;
    cycle();
    check_bit("abort_txd", txd0, 1'b1);
    check_bit("abort_busy", busy0, 1'b0);
    check_bit("abort_req", fifo_req0, 1'b0);
    reset = 1'b0;
    repeat (60) cycle();
    check_int("abort_no_resend", frames_done - base_fr, 0);
    check_bit("abort_idle_txd", txd0, 1'b1);
    base_req = req_cnt;
    push_word(8'h3C);
    wait_frames(base_fr + 1, 100);
    repeat (5) cycle();
    check_int("post_abort_req", req_cnt - base_req, 1);

    // Two stop bits, byte 0x80: 44-cycle frame with 8 high stop cycles
    ld1 = ld1 + 1;
    wait_low(1);
    for (int k = 0; k < FRAME1; k++) begin
      check_bit("sb2_line", txd1, line_bit(8'h80, k / CPB));
      check_bit("sb2_busy", busy1, 1'b1);
      cycle();
    end
    check_bit("sb2_busy_drop", busy1, 1'b0);
    check_bit("sb2_idle_txd", txd1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
